// File: rtl/riscv_v_dispatch_queue_pkg.sv
// Shared types and constants for the scalar-to-vector dispatch queue.
package riscv_v_dispatch_queue_pkg;

  localparam int unsigned RISCV_V_XLEN   = 32;
  localparam int unsigned RISCV_V_INST_W = 32;

  localparam int unsigned RISCV_V_EXT_WR_VSSTATUS = 0;
  localparam int unsigned RISCV_V_EXT_WR_VTYPE    = 1;
  localparam int unsigned RISCV_V_EXT_WR_VL       = 2;
  localparam int unsigned RISCV_V_EXT_WR_VSTART   = 3;
  localparam int unsigned RISCV_V_EXT_WR_VXRM     = 4;
  localparam int unsigned RISCV_V_EXT_WR_VXSAT    = 5;
  localparam int unsigned RISCV_V_CSR_W = RISCV_V_EXT_WR_VXSAT + 1;

  typedef logic [RISCV_V_EXT_WR_VXSAT:RISCV_V_EXT_WR_VSSTATUS] riscv_v_ext_wr_t;

  typedef struct packed {
    logic [RISCV_V_INST_W-1:0] instruction;
    logic [RISCV_V_XLEN-1:0]   rs1_data;
    logic [RISCV_V_XLEN-1:0]   ext_data;
    riscv_v_ext_wr_t           ext_wr;
    logic                      pending;
  } riscv_v_dq_entry_t;

endpackage

// File: rtl/riscv_v_dispatch_queue_if.sv
// Issue/return bus between the dispatch queue (master) and the vector unit (slave).
interface riscv_v_dispatch_queue_if
  import riscv_v_dispatch_queue_pkg::*;
#(
  parameter int unsigned XLEN   = RISCV_V_XLEN,
  parameter int unsigned INST_W = RISCV_V_INST_W,
  parameter int unsigned CSR_W  = RISCV_V_CSR_W
) ();

  logic              vu_valid;
  logic              vu_ready;
  logic [INST_W-1:0] vu_instruction;
  logic [XLEN-1:0]   vu_rs1_data;
  logic [XLEN-1:0]   vu_ext_data;
  logic [CSR_W-1:0]  vu_ext_wr;
  logic              vu_ret_valid;
  logic [XLEN-1:0]   vu_ret_data;

  modport master (
    output vu_valid, vu_instruction, vu_rs1_data, vu_ext_data, vu_ext_wr,
    input  vu_ready, vu_ret_valid, vu_ret_data
  );

  modport slave (
    input  vu_valid, vu_instruction, vu_rs1_data, vu_ext_data, vu_ext_wr,
    output vu_ready, vu_ret_valid, vu_ret_data
  );

endinterface

// File: rtl/riscv_v_dq_mem.sv
// Entry storage: full-entry allocation write, EXE operand back-fill write, head read.
module riscv_v_dq_mem
  import riscv_v_dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       alloc_en,
  input  logic [$clog2(DEPTH)-1:0]   alloc_ptr,
  input  riscv_v_dq_entry_t          alloc_entry,
  input  logic                       cap_en,
  input  logic [$clog2(DEPTH)-1:0]   cap_ptr,
  input  logic [RISCV_V_XLEN-1:0]    cap_data,
  input  logic                       pop_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output riscv_v_dq_entry_t          rd_entry,
  output logic                       rd_valid
);

  riscv_v_dq_entry_t mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i].pending <= 1'b0;
    end else begin
      // Allocation never targets the head while it is poppable, so the pop
      // clear and the allocation set cannot collide on one index.
      if (pop_en) valid[rd_ptr] <= 1'b0;
      if (alloc_en) begin
        mem[alloc_ptr]   <= alloc_entry;
        valid[alloc_ptr] <= 1'b1;
      end
      if (cap_en) begin
        mem[cap_ptr].ext_data <= cap_data;
        mem[cap_ptr].pending  <= 1'b0;
      end
    end
  end

  assign rd_entry = mem[rd_ptr];
  assign rd_valid = valid[rd_ptr];

endmodule

// File: rtl/riscv_v_dispatch_queue.sv
// In-order dispatch queue decoupling the scalar ID/EXE stages from the vector unit,
// with a registered scalar writeback path back to the integer register file.
module riscv_v_dispatch_queue
  import riscv_v_dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned XLEN   = RISCV_V_XLEN,
  parameter int unsigned INST_W = RISCV_V_INST_W,
  parameter int unsigned CSR_W  = RISCV_V_CSR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_pipe,
  input  logic                       riscv_stall,
  input  logic                       id_valid,
  input  logic [INST_W-1:0]          instruction_id,
  input  logic [XLEN-1:0]            int_rf_rd_data_id,
  input  logic [CSR_W-1:0]           ext_wr_id,
  input  logic [XLEN-1:0]            ext_data_in_exe,
  output logic                       riscv_v_stall,
  output logic [$clog2(DEPTH+1)-1:0] count,
  riscv_v_dispatch_queue_if.master   vu,
  output logic                       int_rf_wr_en_wb,
  output logic [XLEN-1:0]            int_rf_wr_data_wb
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, exe_capture_ptr;
  logic              exe_capture_valid;
  logic              full, alloc, capture, pop;
  logic              head_valid;
  riscv_v_dq_entry_t alloc_entry, head;

  assign full          = (count == CNT_W'(DEPTH));
  assign riscv_v_stall = full;

  // Full is judged on the registered count: a same-cycle pop does not open a slot.
  assign alloc   = id_valid & ~riscv_stall & ~clear_pipe & ~full;
  assign capture = exe_capture_valid & ~riscv_stall & ~clear_pipe;
  assign pop     = vu.vu_valid & vu.vu_ready;

  always_comb begin
    alloc_entry             = '0;
    alloc_entry.instruction = instruction_id;
    alloc_entry.rs1_data    = int_rf_rd_data_id;
    alloc_entry.ext_wr      = ext_wr_id;
    alloc_entry.pending     = 1'b1;
  end

  riscv_v_dq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear_pipe),
    .alloc_en    (alloc),
    .alloc_ptr   (wr_ptr),
    .alloc_entry (alloc_entry),
    .cap_en      (capture),
    .cap_ptr     (exe_capture_ptr),
    .cap_data    (ext_data_in_exe),
    .pop_en      (pop),
    .rd_ptr      (rd_ptr),
    .rd_entry    (head),
    .rd_valid    (head_valid)
  );

  assign vu.vu_valid       = (count != '0) & head_valid & ~head.pending;
  assign vu.vu_instruction = head.instruction;
  assign vu.vu_rs1_data    = head.rs1_data;
  assign vu.vu_ext_data    = head.ext_data;
  assign vu.vu_ext_wr      = head.ext_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      exe_capture_ptr   <= '0;
      exe_capture_valid <= 1'b0;
    end else if (clear_pipe) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      exe_capture_valid <= 1'b0;
    end else begin
      if (alloc) begin
        wr_ptr            <= wr_ptr + PTR_W'(1);
        exe_capture_ptr   <= wr_ptr;
        exe_capture_valid <= 1'b1;
      end else if (capture) begin
        exe_capture_valid <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({alloc, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Writeback commits results of already-issued instructions regardless of flush/stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_rf_wr_en_wb   <= 1'b0;
      int_rf_wr_data_wb <= '0;
    end else begin
      int_rf_wr_en_wb <= vu.vu_ret_valid;
      if (vu.vu_ret_valid) int_rf_wr_data_wb <= vu.vu_ret_data;
    end
  end

endmodule

// File: tb/tb_riscv_v_dispatch_queue.sv
// Self-checking bench: directed table, hand sequences and a queue-based reference model.
module tb_riscv_v_dispatch_queue;
  import riscv_v_dispatch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_pipe, riscv_stall, id_valid;
  logic [31:0] instruction_id, int_rf_rd_data_id, ext_data_in_exe;
  logic [5:0]  ext_wr_id;
  logic        riscv_v_stall;
  logic [2:0]  count;
  logic        int_rf_wr_en_wb;
  logic [31:0] int_rf_wr_data_wb;

  riscv_v_dispatch_queue_if #(.XLEN(32), .INST_W(32), .CSR_W(6)) vu_if ();

  riscv_v_dispatch_queue #(.DEPTH(DEPTH), .XLEN(32), .INST_W(32), .CSR_W(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .clear_pipe        (clear_pipe),
    .riscv_stall       (riscv_stall),
    .id_valid          (id_valid),
    .instruction_id    (instruction_id),
    .int_rf_rd_data_id (int_rf_rd_data_id),
    .ext_wr_id         (ext_wr_id),
    .ext_data_in_exe   (ext_data_in_exe),
    .riscv_v_stall     (riscv_v_stall),
    .count             (count),
    .vu                (vu_if),
    .int_rf_wr_en_wb   (int_rf_wr_en_wb),
    .int_rf_wr_data_wb (int_rf_wr_data_wb)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear_pipe        = 1'b0;
    riscv_stall       = 1'b0;
    id_valid          = 1'b0;
    instruction_id    = '0;
    int_rf_rd_data_id = '0;
    ext_wr_id         = '0;
    ext_data_in_exe   = '0;
    vu_if.vu_ready    = 1'b0;
    vu_if.vu_ret_valid = 1'b0;
    vu_if.vu_ret_data  = '0;
  endtask

  task automatic alloc_in(input logic [31:0] inst, input logic [31:0] rs1);
    id_valid          = 1'b1;
    instruction_id    = inst;
    int_rf_rd_data_id = rs1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] ext;
    logic [5:0]  wr;
    bit          have;
  } mentry_t;

  mentry_t     mq[$];
  bit          cap_pend;
  logic        m_wr_en;
  logic [31:0] m_wr_data;
  int unsigned dut_pops;

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    mq.delete();
    cap_pend  = 1'b0;
    m_wr_en   = 1'b0;
    m_wr_data = '0;
    dut_pops  = 0;
  endtask

  // Checks outputs against the model for the current cycle, advances the model, clocks.
  task automatic model_cycle();
    bit      exp_valid, full;
    mentry_t e;
    exp_valid = (mq.size() > 0) && mq[0].have;
    full      = (mq.size() == DEPTH);
    chk("m_vu_valid", 32'(vu_if.vu_valid), 32'(exp_valid));
    chk("m_count", 32'(count), mq.size());
    chk("m_stall", 32'(riscv_v_stall), 32'(full));
    chk("m_wr_en", 32'(int_rf_wr_en_wb), 32'(m_wr_en));
    chk("m_wr_data", int_rf_wr_data_wb, m_wr_data);
    if (exp_valid) begin
      chk("m_inst", vu_if.vu_instruction, mq[0].inst);
      chk("m_rs1", vu_if.vu_rs1_data, mq[0].rs1);
      chk("m_ext", vu_if.vu_ext_data, mq[0].ext);
      chk("m_ext_wr", 32'(vu_if.vu_ext_wr), 32'(mq[0].wr));
    end
    if (vu_if.vu_valid && vu_if.vu_ready) dut_pops++;
    if (cap_pend && !riscv_stall && !clear_pipe) begin
      mq[mq.size()-1].ext  = ext_data_in_exe;
      mq[mq.size()-1].have = 1'b1;
      cap_pend = 1'b0;
    end
    if (exp_valid && vu_if.vu_ready) void'(mq.pop_front());
    if (id_valid && !riscv_stall && !clear_pipe && !full) begin
      e.inst = instruction_id;
      e.rs1  = int_rf_rd_data_id;
      e.ext  = '0;
      e.wr   = ext_wr_id;
      e.have = 1'b0;
      mq.push_back(e);
      cap_pend = 1'b1;
    end
    if (clear_pipe) begin
      mq.delete();
      cap_pend = 1'b0;
    end
    m_wr_en = vu_if.vu_ret_valid;
    if (vu_if.vu_ret_valid) m_wr_data = vu_if.vu_ret_data;
    step();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        id_valid;
    logic        vu_ready;
    logic [31:0] inst;
    logic [31:0] ext_in;
    logic        exp_valid;
    logic        exp_stall;
    logic [2:0]  exp_count;
    logic [31:0] exp_inst;
    logic [31:0] exp_ext;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(input logic iv, input logic rdy, input logic [31:0] inst,
                              input logic [31:0] ext_in, input logic ev, input logic es,
                              input logic [2:0] ec, input logic [31:0] ei, input logic [31:0] ee);
    vec_t v;
    v.id_valid = iv; v.vu_ready = rdy; v.inst = inst; v.ext_in = ext_in;
    v.exp_valid = ev; v.exp_stall = es; v.exp_count = ec; v.exp_inst = ei; v.exp_ext = ee;
    return v;
  endfunction

  initial begin
    // Fill to DEPTH with the vector unit stalled, attempt a fifth, then drain in order.
    tbl[0] = mk(1'b1, 1'b0, 32'h0000_00A0, 32'h0,         1'b0, 1'b0, 3'd0, 32'h0,         32'h0);
    tbl[1] = mk(1'b1, 1'b0, 32'h0000_00B0, 32'hEEEE_00A0, 1'b0, 1'b0, 3'd1, 32'h0,         32'h0);
    tbl[2] = mk(1'b1, 1'b0, 32'h0000_00C0, 32'hEEEE_00B0, 1'b1, 1'b0, 3'd2, 32'h0000_00A0, 32'hEEEE_00A0);
    tbl[3] = mk(1'b1, 1'b0, 32'h0000_00D0, 32'hEEEE_00C0, 1'b1, 1'b0, 3'd3, 32'h0000_00A0, 32'hEEEE_00A0);
    tbl[4] = mk(1'b1, 1'b0, 32'h0000_00E0, 32'hEEEE_00D0, 1'b1, 1'b1, 3'd4, 32'h0000_00A0, 32'hEEEE_00A0);
    tbl[5] = mk(1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b1, 3'd4, 32'h0000_00A0, 32'hEEEE_00A0);
    tbl[6] = mk(1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 3'd3, 32'h0000_00B0, 32'hEEEE_00B0);
    tbl[7] = mk(1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 3'd2, 32'h0000_00C0, 32'hEEEE_00C0);
    tbl[8] = mk(1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 3'd1, 32'h0000_00D0, 32'hEEEE_00D0);
    tbl[9] = mk(1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 3'd0, 32'h0,         32'h0);

    idle();
    rst = 1'b0;

    // Reset state and single-instruction latency
    do_reset();
    chk("rst_vu_valid", 32'(vu_if.vu_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_stall", 32'(riscv_v_stall), 32'd0);
    chk("rst_wr_en", 32'(int_rf_wr_en_wb), 32'd0);
    chk("rst_wr_data", int_rf_wr_data_wb, 32'd0);
    chk("rst_vu_inst", vu_if.vu_instruction, 32'd0);
    chk("rst_vu_ext", vu_if.vu_ext_data, 32'd0);
    alloc_in(32'h0000_5057, 32'h0000_0011);
    ext_wr_id = '0;
    ext_wr_id[RISCV_V_EXT_WR_VTYPE] = 1'b1;
    ext_wr_id[RISCV_V_EXT_WR_VL]    = 1'b1;
    step();
    idle();
    ext_data_in_exe = 32'hDEAD_BEEF;
    vu_if.vu_ready  = 1'b1;
    chk("t1_valid_c1", 32'(vu_if.vu_valid), 32'd0);
    chk("t1_count_c1", 32'(count), 32'd1);
    step();
    chk("t1_valid_c2", 32'(vu_if.vu_valid), 32'd1);
    chk("t1_inst", vu_if.vu_instruction, 32'h0000_5057);
    chk("t1_ext", vu_if.vu_ext_data, 32'hDEAD_BEEF);
    chk("t1_rs1", vu_if.vu_rs1_data, 32'h0000_0011);
    chk("t1_ext_wr", 32'(vu_if.vu_ext_wr), 32'h06);
    step();
    chk("t1_valid_c3", 32'(vu_if.vu_valid), 32'd0);
    chk("t1_count_c3", 32'(count), 32'd0);

    // Full / backpressure table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      id_valid        = tbl[i].id_valid;
      instruction_id  = tbl[i].inst;
      ext_data_in_exe = tbl[i].ext_in;
      vu_if.vu_ready  = tbl[i].vu_ready;
      chk($sformatf("tbl%0d_valid", i), 32'(vu_if.vu_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_stall", i), 32'(riscv_v_stall), 32'(tbl[i].exp_stall));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_inst", i), vu_if.vu_instruction, tbl[i].exp_inst);
        chk($sformatf("tbl%0d_ext", i), vu_if.vu_ext_data, tbl[i].exp_ext);
      end
      step();
    end

    // Scalar stall between allocation and EXE capture
    do_reset();
    alloc_in(32'h0000_3333, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      riscv_stall     = 1'b1;
      alloc_in(32'h0000_9999, 32'h0);
      ext_data_in_exe = 32'h0000_0BAD;
      chk("t3_stall_valid", 32'(vu_if.vu_valid), 32'd0);
      chk("t3_stall_count", 32'(count), 32'd1);
      step();
    end
    idle();
    ext_data_in_exe = 32'h0000_CAFE;
    chk("t3_cap_valid", 32'(vu_if.vu_valid), 32'd0);
    step();
    idle();
    chk("t3_valid", 32'(vu_if.vu_valid), 32'd1);
    chk("t3_inst", vu_if.vu_instruction, 32'h0000_3333);
    chk("t3_ext", vu_if.vu_ext_data, 32'h0000_CAFE);
    vu_if.vu_ready = 1'b1;
    step();
    chk("t3_count_end", 32'(count), 32'd0);

    // Simultaneous allocation and pop at count=2
    do_reset();
    alloc_in(32'h41, 32'h0);
    step();
    alloc_in(32'h42, 32'h0);
    ext_data_in_exe = 32'hE41;
    step();
    idle();
    ext_data_in_exe = 32'hE42;
    step();
    chk("t4_count_pre", 32'(count), 32'd2);
    chk("t4_inst_pre", vu_if.vu_instruction, 32'h41);
    alloc_in(32'h43, 32'h0);
    vu_if.vu_ready = 1'b1;
    step();
    chk("t4_count_same", 32'(count), 32'd2);
    chk("t4_inst_mid", vu_if.vu_instruction, 32'h42);
    chk("t4_ext_mid", vu_if.vu_ext_data, 32'hE42);
    id_valid        = 1'b0;
    ext_data_in_exe = 32'hE43;
    step();
    chk("t4_inst_last", vu_if.vu_instruction, 32'h43);
    chk("t4_ext_last", vu_if.vu_ext_data, 32'hE43);
    chk("t4_count_last", 32'(count), 32'd1);
    step();
    chk("t4_count_end", 32'(count), 32'd0);

    // Wrap: 10 back-to-back instructions through the queue
    do_reset();
    for (int i = 0; i < 24; i++) begin
      id_valid          = (i < 10);
      instruction_id    = 32'h100 + 32'(i);
      int_rf_rd_data_id = $urandom();
      ext_wr_id         = 6'($urandom());
      ext_data_in_exe   = $urandom();
      vu_if.vu_ready    = 1'b1;
      model_cycle();
    end
    chk("wrap_issued", dut_pops, 32'd10);

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      id_valid           = ($urandom_range(0, 99) < 60);
      riscv_stall        = ($urandom_range(0, 99) < 20);
      clear_pipe         = ($urandom_range(0, 99) < 3);
      vu_if.vu_ready     = ($urandom_range(0, 99) < 55);
      vu_if.vu_ret_valid = ($urandom_range(0, 99) < 50);
      vu_if.vu_ret_data  = $urandom();
      instruction_id     = $urandom();
      int_rf_rd_data_id  = $urandom();
      ext_wr_id          = 6'($urandom());
      ext_data_in_exe    = $urandom();
      model_cycle();
    end

    // Flush with three queued entries, a same-cycle allocation and a writeback
    do_reset();
    alloc_in(32'h51, 32'h0);
    step();
    alloc_in(32'h52, 32'h0);
    ext_data_in_exe = 32'hE51;
    step();
    alloc_in(32'h53, 32'h0);
    ext_data_in_exe = 32'hE52;
    step();
    idle();
    ext_data_in_exe = 32'hE53;
    step();
    chk("t5_count_pre", 32'(count), 32'd3);
    clear_pipe         = 1'b1;
    alloc_in(32'h54, 32'h0);
    vu_if.vu_ret_valid = 1'b1;
    vu_if.vu_ret_data  = 32'h1234;
    step();
    idle();
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_valid", 32'(vu_if.vu_valid), 32'd0);
    chk("t5_stall", 32'(riscv_v_stall), 32'd0);
    chk("t5_wr_en", 32'(int_rf_wr_en_wb), 32'd1);
    chk("t5_wr_data", int_rf_wr_data_wb, 32'h1234);
    step();
    chk("t5_count_after", 32'(count), 32'd0);
    chk("t5_valid_after", 32'(vu_if.vu_valid), 32'd0);
    chk("t5_wr_en_after", 32'(int_rf_wr_en_wb), 32'd0);
    chk("t5_wr_hold", int_rf_wr_data_wb, 32'h1234);

    // Asynchronous reset mid-stream
    do_reset();
    alloc_in(32'h61, 32'h77);
    ext_wr_id = 6'h3F;
    step();
    idle();
    ext_data_in_exe    = 32'hE61;
    vu_if.vu_ret_valid = 1'b1;
    vu_if.vu_ret_data  = 32'h5A5A;
    step();
    idle();
    chk("t6_pre_valid", 32'(vu_if.vu_valid), 32'd1);
    chk("t6_pre_wr_en", 32'(int_rf_wr_en_wb), 32'd1);
    chk("t6_pre_wr_data", int_rf_wr_data_wb, 32'h5A5A);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(vu_if.vu_valid), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_stall", 32'(riscv_v_stall), 32'd0);
    chk("t6_wr_en", 32'(int_rf_wr_en_wb), 32'd0);
    chk("t6_wr_data", int_rf_wr_data_wb, 32'd0);
    chk("t6_inst", vu_if.vu_instruction, 32'd0);
    chk("t6_rs1", vu_if.vu_rs1_data, 32'd0);
    chk("t6_ext", vu_if.vu_ext_data, 32'd0);
    chk("t6_ext_wr", 32'(vu_if.vu_ext_wr), 32'd0);
    step();
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
